operand_accumulator: RTL
========================

OPERAND_ACCUMULATOR -- requirements
Module: operand_accumulator

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of decimal digits held (range 1..8).
REQ-002 Parameter BIN_W, default 14, SHALL set the binary operand width and SHALL be >= ceil(log2(10^NUM_DIGITS)).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 digit_in  input  4  SHALL carry the BCD digit to push.
REQ-006 digit_valid  input  1  SHALL request a push of digit_in (one push per high cycle).
REQ-007 backspace  input  1  SHALL request removal of the least significant entered digit.
REQ-008 clear  input  1  SHALL request an entry clear.
REQ-009 commit  input  1  SHALL request transfer of the current entry to the output.
REQ-010 out_ready  input  1  SHALL indicate the consumer accepts out_bcd/out_bin.
REQ-011 entry_bcd  output  4*NUM_DIGITS  SHALL show the current entry in packed BCD, LSD in [3:0].
REQ-012 entry_bin  output  BIN_W  SHALL show the binary value of the current entry.
REQ-013 count  output  $clog2(NUM_DIGITS+1)  SHALL show the number of digits entered.
REQ-014 full  output  1  SHALL be high when count == NUM_DIGITS.
REQ-015 busy  output  1  SHALL be high in RECALC or HOLD.
REQ-016 out_valid, out_bcd, out_bin  output  1, 4*NUM_DIGITS, BIN_W  SHALL form the committed-operand handshake.
REQ-017 err  output  1  SHALL pulse high for exactly one cycle on any rejected request.

Function
REQ-018 State machine SHALL have states ENTRY, RECALC, HOLD.
REQ-019 In ENTRY, same-cycle requests SHALL be resolved by priority clear > commit > backspace > digit_valid; lower-priority requests that cycle SHALL be discarded without err.
REQ-020 Push in ENTRY: entry_bcd shifts left 4 bits with digit_in in [3:0], entry_bin <= entry_bin*10 + digit_in, count increments; visible next cycle.
REQ-021 Push with digit_in > 9, or with full high, SHALL be rejected: entry unchanged, err pulse.
REQ-022 clear in ENTRY SHALL zero entry_bcd, entry_bin, count next cycle.
REQ-023 backspace in ENTRY with count > 0: entry_bcd shifts right 4 bits, count decrements, entry_bin <= 0, state -> RECALC; with count == 0: no-op, no err.
REQ-024 RECALC SHALL last exactly NUM_DIGITS cycles, each computing entry_bin <= entry_bin*10 + next BCD digit, MSD first; then state -> ENTRY with entry_bin correct.
REQ-025 In RECALC, digit_valid, backspace and commit SHALL be ignored with err pulse; clear SHALL abort RECALC, zero the entry, and return to ENTRY.
REQ-026 commit in ENTRY with count > 0: out_bcd/out_bin <= entry values, out_valid <= 1, entry zeroed, state -> HOLD; with count == 0: rejected, err pulse.
REQ-027 In HOLD, out_valid, out_bcd, out_bin SHALL stay stable until a cycle with out_ready high; that cycle SHALL complete the transfer, and next cycle out_valid = 0, state = ENTRY.
REQ-028 In HOLD, all entry requests including clear SHALL be ignored with err pulse.
REQ-029 Arithmetic SHALL be unsigned, full precision within BIN_W; no overflow is possible given REQ-002.

Reset
REQ-030 On rst low, immediately and regardless of clk: state ENTRY; entry_bcd, entry_bin, count, out_bcd, out_bin = 0; full, busy, out_valid, err = 0.
REQ-031 Reset asserted mid-RECALC or mid-HOLD SHALL discard all pending work; no output transfer SHALL occur.

Verification (NUM_DIGITS=4, BIN_W=14)
REQ-032 Push 1,2,3,4 -> entry_bcd=0x1234, entry_bin=1234, count=4, full=1; push 5 -> err pulse, entry unchanged.
REQ-033 From 0x1234, backspace -> busy high exactly 4 cycles, then entry_bcd=0x0123, entry_bin=123, count=3.
REQ-034 Entry 0x0987, commit, out_ready low 3 cycles then high -> out_valid high 4 cycles, out_bin=987, out_bcd=0x0987 stable throughout; entry zeroed; ENTRY after transfer.
REQ-035 digit_in=0xA with digit_valid -> err pulse, no change; commit at count=0 -> err pulse, out_valid stays 0.
REQ-036 Same cycle clear+digit_valid(7) with entry 0x0042 -> entry_bcd=0, count=0, no err.
REQ-037 rst low during cycle 2 of RECALC -> all outputs 0 immediately; after release, push 3 -> entry_bin=3.

Source files
------------

// File: rtl/operand_accumulator.sv
// operand_accumulator: collects BCD digits into an operand, keeping a packed
// BCD copy and a running binary value. The operand is handed off through a
// valid/ready handshake. After a backspace the binary value is rebuilt from
// the BCD digits over NUM_DIGITS cycles (RECALC).
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   digit_in, digit_valid  BCD digit to push
//   backspace, clear, commit  entry edit / hand-off requests
//   out_ready           consumer accepts out_bcd/out_bin
//   entry_bcd, entry_bin, count, full  current entry state
//   busy                high in RECALC or HOLD
//   out_valid, out_bcd, out_bin  committed operand handshake
//   err                 one-cycle pulse on a rejected request
module operand_accumulator #(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned BIN_W      = 14
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [3:0]                      digit_in,
   input  logic                            digit_valid,
   input  logic                            backspace,
   input  logic                            clear,
   input  logic                            commit,
   input  logic                            out_ready,
   output logic [4*NUM_DIGITS-1:0]         entry_bcd,
   output logic [BIN_W-1:0]                entry_bin,
   output logic [$clog2(NUM_DIGITS+1)-1:0] count,
   output logic                            full,
   output logic                            busy,
   output logic                            out_valid,
   output logic [4*NUM_DIGITS-1:0]         out_bcd,
   output logic [BIN_W-1:0]                out_bin,
   output logic                            err
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [1:0] ST_ENTRY  = 2'd0;
   localparam logic [1:0] ST_RECALC = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   logic [1:0]       state_q,     state_d;
   logic [BCD_W-1:0] entry_bcd_q, entry_bcd_d;
   logic [BIN_W-1:0] entry_bin_q, entry_bin_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic [IDX_W-1:0] idx_q,       idx_d;
   logic             full_q,      full_d;
   logic             busy_q,      busy_d;
   logic             out_valid_q, out_valid_d;
   logic [BCD_W-1:0] out_bcd_q,   out_bcd_d;
   logic [BIN_W-1:0] out_bin_q,   out_bin_d;
   logic             err_q,       err_d;
   logic [3:0]       rc_digit;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_ENTRY;
         entry_bcd_q <= '0;
         entry_bin_q <= '0;
         count_q     <= '0;
         idx_q       <= '0;
         full_q      <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_bcd_q   <= '0;
         out_bin_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         entry_bcd_q <= entry_bcd_d;
         entry_bin_q <= entry_bin_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         full_q      <= full_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_bcd_q   <= out_bcd_d;
         out_bin_q   <= out_bin_d;
         err_q       <= err_d;
      end
   end

   // Digit currently feeding the rebuild, walked MSD first
   always_comb begin
      rc_digit = 4'd0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (idx_q == IDX_W'(i)) rc_digit = entry_bcd_q[4*i +: 4];
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      entry_bcd_d = entry_bcd_q;
      entry_bin_d = entry_bin_q;
      count_d     = count_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_bcd_d   = out_bcd_q;
      out_bin_d   = out_bin_q;
      err_d       = 1'b0;

      case (state_q)
         ST_ENTRY: begin
            if (clear) begin
               entry_bcd_d = '0;
               entry_bin_d = '0;
               count_d     = '0;
            end else if (commit) begin
               if (count_q != '0) begin
                  out_bcd_d   = entry_bcd_q;
                  out_bin_d   = entry_bin_q;
                  out_valid_d = 1'b1;
                  entry_bcd_d = '0;
                  entry_bin_d = '0;
                  count_d     = '0;
                  state_d     = ST_HOLD;
               end else begin
                  err_d = 1'b1;
               end
            end else if (backspace) begin
               // Binary value cannot be divided back cheaply; rebuild it instead
               if (count_q != '0) begin
                  entry_bcd_d = entry_bcd_q >> 4;
                  count_d     = count_q - CNT_W'(1);
                  entry_bin_d = '0;
                  idx_d       = IDX_W'(NUM_DIGITS - 1);
                  state_d     = ST_RECALC;
               end
            end else if (digit_valid) begin
               if ((digit_in > 4'd9) || (count_q == CNT_W'(NUM_DIGITS))) begin
                  err_d = 1'b1;
               end else begin
                  entry_bcd_d = (entry_bcd_q << 4) | BCD_W'(digit_in);
                  entry_bin_d = (entry_bin_q * BIN_W'(10)) + BIN_W'(digit_in);
                  count_d     = count_q + CNT_W'(1);
               end
            end
         end

         ST_RECALC: begin
            if (clear) begin
               entry_bcd_d = '0;
               entry_bin_d = '0;
               count_d     = '0;
               state_d     = ST_ENTRY;
            end else begin
               if (digit_valid || backspace || commit) err_d = 1'b1;
               // Leading zero digits contribute nothing, so all slots are walked
               entry_bin_d = (entry_bin_q * BIN_W'(10)) + BIN_W'(rc_digit);
               if (idx_q == '0) begin
                  state_d = ST_ENTRY;
               end else begin
                  idx_d = idx_q - IDX_W'(1);
               end
            end
         end

         ST_HOLD: begin
            if (digit_valid || backspace || clear || commit) err_d = 1'b1;
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_ENTRY;
            end
         end

         default: begin
            state_d = ST_ENTRY;
         end
      endcase

      full_d = (count_d == CNT_W'(NUM_DIGITS));
      busy_d = (state_d != ST_ENTRY);
   end

   assign entry_bcd = entry_bcd_q;
   assign entry_bin = entry_bin_q;
   assign count     = count_q;
   assign full      = full_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_bcd   = out_bcd_q;
   assign out_bin   = out_bin_q;
   assign err       = err_q;

endmodule
